// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions.
// Holds the master-side state encoding reused by the AXIS blocks.
package axis_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } axis_state_e;

endpackage

// File: rtl/axis_packet_gen.sv
// AXI-Stream packet generator: emits pkt_len beats counting up from seed.
// Ports: aclk/areset (sync, active-high)/aclken; start, pkt_len, seed
// request a packet; m_tdata/m_tvalid/m_tlast/m_tready form the stream;
// busy while sending, done pulses after the last beat, pkt_count counts.
module axis_packet_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  aclken,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  pkt_len,
    input  logic [DATA_WIDTH-1:0] seed,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           pkt_count
);

    import axis_pkg::*;

    axis_state_e          state;
    // Beats still to follow the one on the bus; counts down, so a
    // maximum-length packet never needs a wider counter.
    logic [LEN_WIDTH-1:0] remaining;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state     <= IDLE;
            remaining <= '0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pkt_count <= '0;
        end else if (aclken) begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && pkt_len != '0) begin
                        state     <= SEND;
                        remaining <= pkt_len - LEN_WIDTH'(1);
                        m_tdata   <= seed;
                        m_tvalid  <= 1'b1;
                        m_tlast   <= (pkt_len == LEN_WIDTH'(1));
                        busy      <= 1'b1;
                    end
                end
                SEND: begin
                    // m_tvalid is always high here, so m_tready alone
                    // decides the handshake.
                    if (m_tready) begin
                        if (remaining == '0) begin
                            state     <= IDLE;
                            m_tvalid  <= 1'b0;
                            m_tlast   <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pkt_count <= pkt_count + 16'd1;
                        end else begin
                            remaining <= remaining - LEN_WIDTH'(1);
                            m_tdata   <= m_tdata + DATA_WIDTH'(1);
                            m_tlast   <= (remaining == LEN_WIDTH'(1));
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_gen.sv
// Directed, table-driven bench for axis_packet_gen.
// Each row drives one clock of inputs and states the outputs after that edge.
module tb_axis_packet_gen;

    logic        aclk;
    logic        areset;
    logic        aclken;
    logic        start;
    logic [15:0] pkt_len;
    logic [7:0]  seed;
    logic [7:0]  m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;

    int n_checks = 0;
    int n_fail   = 0;

    axis_packet_gen #(.DATA_WIDTH(8), .LEN_WIDTH(16)) dut (
        .aclk      (aclk),
        .areset    (areset),
        .aclken    (aclken),
        .start     (start),
        .pkt_len   (pkt_len),
        .seed      (seed),
        .m_tdata   (m_tdata),
        .m_tvalid  (m_tvalid),
        .m_tlast   (m_tlast),
        .m_tready  (m_tready),
        .busy      (busy),
        .done      (done),
        .pkt_count (pkt_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic        ar;
        logic        en;
        logic        st;
        logic [15:0] len;
        logic [7:0]  sd;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        eb;
        logic        edn;
        logic [15:0] ec;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(
        input logic ar, input logic en, input logic st,
        input logic [15:0] len, input logic [7:0] sd, input logic rdy,
        input logic ev, input logic [7:0] ed, input logic el,
        input logic eb, input logic edn, input logic [15:0] ec);
        vec_t v;
        v.ar = ar; v.en = en; v.st = st; v.len = len; v.sd = sd;
        v.rdy = rdy; v.ev = ev; v.ed = ed; v.el = el; v.eb = eb;
        v.edn = edn; v.ec = ec;
        vecs.push_back(v);
    endfunction

    task automatic check(input int row, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL row %0d %s: got %h, want %h", row, name, act, exp);
        end
    endtask

    initial begin
        int errs;
        areset = 1'b1; aclken = 1'b1; start = 1'b0;
        pkt_len = '0; seed = '0; m_tready = 1'b0;

        //   ar en st len      seed   rdy  ev ed     el eb dn cnt
        // reset
        add(1, 1, 0, 16'd0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 16'd0);
        add(0, 1, 0, 16'd0, 8'h00, 0,   0, 8'h00, 0, 0, 0, 16'd0);
        // single packet, seed 0x10, len 4
        add(0, 1, 1, 16'd4, 8'h10, 1,   1, 8'h10, 0, 1, 0, 16'd0);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h11, 0, 1, 0, 16'd0);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h12, 0, 1, 0, 16'd0);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h13, 1, 1, 0, 16'd0);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 16'd1);
        // backpressure, seed 0x20, len 4
        add(0, 1, 1, 16'd4, 8'h20, 0,   1, 8'h20, 0, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h21, 0, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 0,   1, 8'h21, 0, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 0,   1, 8'h21, 0, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h22, 0, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 0,   1, 8'h22, 0, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 0,   1, 8'h22, 0, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h23, 1, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 0,   1, 8'h23, 1, 1, 0, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd2);
        // wrap FE,FF,00; start on final handshake ignored
        add(0, 1, 1, 16'd3, 8'hFE, 1,   1, 8'hFE, 0, 1, 0, 16'd2);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'hFF, 0, 1, 0, 16'd2);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h00, 1, 1, 0, 16'd2);
        add(0, 1, 1, 16'd1, 8'h55, 1,   0, 8'h00, 0, 0, 1, 16'd3);
        // start on done cycle, len 1
        add(0, 1, 1, 16'd1, 8'h55, 0,   1, 8'h55, 1, 1, 0, 16'd3);
        add(0, 1, 0, 16'd0, 8'h00, 0,   1, 8'h55, 1, 1, 0, 16'd3);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd4);
        // len 0 ignored
        add(0, 1, 1, 16'd0, 8'h77, 1,   0, 8'h00, 0, 0, 0, 16'd4);
        add(0, 1, 1, 16'd0, 8'h77, 1,   0, 8'h00, 0, 0, 0, 16'd4);
        // start mid-packet ignored
        add(0, 1, 1, 16'd3, 8'h30, 1,   1, 8'h30, 0, 1, 0, 16'd4);
        add(0, 1, 1, 16'd5, 8'h99, 1,   1, 8'h31, 0, 1, 0, 16'd4);
        add(0, 1, 1, 16'd5, 8'h99, 1,   1, 8'h32, 1, 1, 0, 16'd4);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd5);
        // aclken low mid-packet
        add(0, 1, 1, 16'd3, 8'h40, 0,   1, 8'h40, 0, 1, 0, 16'd5);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h41, 0, 1, 0, 16'd5);
        add(0, 0, 1, 16'd2, 8'h00, 1,   1, 8'h41, 0, 1, 0, 16'd5);
        add(0, 0, 0, 16'd0, 8'h00, 1,   1, 8'h41, 0, 1, 0, 16'd5);
        add(0, 0, 0, 16'd0, 8'h00, 1,   1, 8'h41, 0, 1, 0, 16'd5);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h42, 1, 1, 0, 16'd5);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd6);
        // done holds while aclken low
        add(0, 0, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd6);
        add(0, 0, 1, 16'd2, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd6);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 16'd6);
        // reset on beat 2 of 5, with aclken low
        add(0, 1, 1, 16'd5, 8'h50, 0,   1, 8'h50, 0, 1, 0, 16'd6);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h51, 0, 1, 0, 16'd6);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h52, 0, 1, 0, 16'd6);
        add(1, 0, 1, 16'd2, 8'h00, 1,   0, 8'h00, 0, 0, 0, 16'd0);
        // first start right after reset
        add(0, 1, 1, 16'd2, 8'h60, 0,   1, 8'h60, 0, 1, 0, 16'd0);
        add(0, 1, 0, 16'd0, 8'h00, 1,   1, 8'h61, 1, 1, 0, 16'd0);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 1, 16'd1);
        add(0, 1, 0, 16'd0, 8'h00, 1,   0, 8'h00, 0, 0, 0, 16'd1);

        foreach (vecs[r]) begin
            areset   = vecs[r].ar;
            aclken   = vecs[r].en;
            start    = vecs[r].st;
            pkt_len  = vecs[r].len;
            seed     = vecs[r].sd;
            m_tready = vecs[r].rdy;
            @(posedge aclk);
            #1;
            check(r, "tvalid", 32'(m_tvalid), 32'(vecs[r].ev));
            check(r, "tlast", 32'(m_tlast), 32'(vecs[r].el));
            check(r, "busy", 32'(busy), 32'(vecs[r].eb));
            check(r, "done", 32'(done), 32'(vecs[r].edn));
            check(r, "pkt_count", 32'(pkt_count), 32'(vecs[r].ec));
            if (vecs[r].ev || vecs[r].ar)
                check(r, "tdata", 32'(m_tdata), 32'(vecs[r].ed));
        end

        // Maximum-length packet: 65535 beats, tlast only on the last.
        areset = 1'b0; aclken = 1'b1; m_tready = 1'b1;
        start = 1'b1; pkt_len = 16'hFFFF; seed = 8'h00;
        @(posedge aclk);
        #1;
        start = 1'b0;
        errs = 0;
        for (int i = 0; i < 65535; i++) begin
            if (!(m_tvalid && m_tdata == i[7:0] &&
                  m_tlast == (i == 65534) && busy))
                errs++;
            @(posedge aclk);
            #1;
        end
        check(1000, "maxlen_beats", 32'(errs), 32'd0);
        check(1001, "maxlen_tvalid", 32'(m_tvalid), 32'd0);
        check(1002, "maxlen_done", 32'(done), 32'd1);
        check(1003, "maxlen_count", 32'(pkt_count), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_packet_gen.md
AXIS_PACKET_GEN -- requirements
Module: axis_packet_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of m_tdata and seed.
REQ-002 Parameter LEN_WIDTH, default 16: width of pkt_len and of the beat counter.
REQ-003 Port aclk, input, 1: the only clock; all logic is on its rising edge.
REQ-004 Port areset, input, 1: reset, synchronous to aclk, active-high.
REQ-005 Port aclken, input, 1: clock enable; when low, all state and outputs hold.
REQ-006 Port start, input, 1: request to emit one packet; sampled only in IDLE.
REQ-007 Port pkt_len, input, LEN_WIDTH: packet length in beats; sampled with start.
REQ-008 Port seed, input, DATA_WIDTH: data value of beat 0; sampled with start.
REQ-009 Port m_tdata, output, DATA_WIDTH: stream data.
REQ-010 Port m_tvalid, output, 1: stream valid.
REQ-011 Port m_tlast, output, 1: marks the final beat of a packet.
REQ-012 Port m_tready, input, 1: downstream ready.
REQ-013 Port busy, output, 1: high while in SEND.
REQ-014 Port done, output, 1: one-cycle pulse after the final beat is accepted.
REQ-015 Port pkt_count, output, 16: number of completed packets; wraps 0xFFFF->0x0000.

Function
REQ-016 Block SHALL be an AXI-Stream master with two states: IDLE and SEND.
REQ-017 A handshake SHALL occur on a cycle with aclken=1, m_tvalid=1 and m_tready=1.
REQ-018 IDLE with aclken=1, start=1, pkt_len!=0 SHALL go to SEND next cycle, with m_tvalid=1, m_tdata=seed, busy=1.
REQ-019 Latency from start to first valid beat SHALL be exactly one aclken cycle.
REQ-020 start with pkt_len=0 SHALL be ignored: stay IDLE, no beat, no done.
REQ-021 start SHALL be ignored while busy=1, including on the final-beat handshake cycle.
REQ-022 Beat k (0-based) SHALL carry m_tdata = seed + k mod 2^DATA_WIDTH; the sum wraps silently.
REQ-023 Once m_tvalid=1, m_tvalid, m_tdata and m_tlast SHALL stay stable until a handshake.
REQ-024 m_tvalid SHALL never depend combinationally on m_tready; all outputs SHALL be registered.
REQ-025 After a non-final handshake, the next beat SHALL be presented in the following cycle, with no bubble.
REQ-026 m_tlast SHALL be 1 only on beat pkt_len-1; for pkt_len=1 it SHALL be 1 on beat 0.
REQ-027 Final-beat handshake SHALL, in the next cycle: enter IDLE, set m_tvalid=0, m_tlast=0, busy=0, pulse done=1, and increment pkt_count.
REQ-028 done SHALL be 1 for exactly one cycle; the earliest a new start is accepted is that same cycle.
REQ-029 pkt_len=2^LEN_WIDTH-1 SHALL emit exactly that many beats; the counter SHALL NOT overflow.
REQ-030 With aclken=0, no handshake SHALL occur and done SHALL hold its value.

Reset
REQ-031 areset=1 SHALL take priority over aclken and all other inputs.
REQ-032 On reset, outputs SHALL be: m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0, pkt_count=0; state SHALL be IDLE.
REQ-033 Reset during SEND SHALL abort the packet, emit no further beat, and not pulse done.
REQ-034 The first start SHALL be accepted on the first aclken cycle after areset deasserts.

Structure
REQ-035 The state enum (IDLE, SEND) SHALL live in a shared package axis_pkg for reuse by other AXIS blocks.
REQ-036 The block SHALL be a single module with no sub-module; beat counter and data adder are inline.

Verification
REQ-037 Single packet: seed=0x10, pkt_len=4, m_tready=1 -> data 10,11,12,13 on consecutive cycles; tlast on 0x13; done one cycle later; pkt_count=1.
REQ-038 Backpressure: m_tready toggling 1,0,0,1,... -> data and tlast stable during stalls; 4 beats total; no beat lost or duplicated.
REQ-039 Wrap and short packet: seed=0xFE, pkt_len=3 -> data FE, FF, 00; then pkt_len=1 -> one beat with tlast=1.
REQ-040 Ignored requests: pkt_len=0 -> no valid, no done; start pulsed mid-packet -> ignored; start on the done cycle -> next packet begins the cycle after.
REQ-041 Reset mid-packet: areset on beat 2 of 5 -> m_tvalid=0 next cycle, pkt_count=0, no done; a later start yields a full, correct packet.
REQ-042 aclken: aclken=0 for 3 cycles mid-packet -> outputs frozen; the packet then completes with correct data and count.
